// File: rtl/sub_su_pipe.sv
// Streaming signed-minus-unsigned subtractor: two registered stages with valid/ready
// on both sides, optional output saturation and a wrapping transaction counter.
module sub_su_pipe #(
    parameter int WIDTH = 8,
    parameter int OUT_W = WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_diff,
    output logic                    out_sat,
    output logic [15:0]             txn_count
);

    localparam int FW = WIDTH + 2;

    logic                    r_s1_v;
    logic [WIDTH-1:0]        r_s1_a;
    logic [WIDTH-1:0]        r_s1_b;
    logic                    r_s2_v;
    logic signed [OUT_W-1:0] r_s2_diff;
    logic                    r_s2_sat;
    logic [15:0]             r_txn_count;

    logic                    w_s2_ready;
    logic                    w_s1_move;
    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic signed [FW-1:0]    w_full;
    logic signed [OUT_W-1:0] w_diff;
    logic                    w_sat;

    // in_ready looks only at pipeline state and out_ready, never at in_valid.
    assign w_s2_ready = !r_s2_v || out_ready;
    assign w_s1_move  = r_s1_v && w_s2_ready;
    assign in_ready   = !r_s1_v || w_s2_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_s2_v && out_ready;

    assign w_full = $signed({{2{r_s1_a[WIDTH-1]}}, r_s1_a}) - $signed({2'b00, r_s1_b});

    generate
        if (OUT_W < FW) begin : g_sat
            localparam logic signed [FW-1:0] SAT_MAX = {{(FW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [FW-1:0] SAT_MIN = {{(FW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

            always_comb begin
                w_diff = w_full[OUT_W-1:0];
                w_sat  = 1'b0;
                if (w_full > SAT_MAX) begin
                    w_diff = SAT_MAX[OUT_W-1:0];
                    w_sat  = 1'b1;
                end else if (w_full < SAT_MIN) begin
                    w_diff = SAT_MIN[OUT_W-1:0];
                    w_sat  = 1'b1;
                end
            end
        end else begin : g_full
            assign w_diff = w_full;
            assign w_sat  = 1'b0;
        end
    endgenerate

    // NOTE: stage data registers are reset too, so out_diff reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_s1_v <= 1'b0;
            r_s1_a <= '0;
            r_s1_b <= '0;
        end else if (w_in_xfer) begin
            r_s1_v <= 1'b1;
            r_s1_a <= a;
            r_s1_b <= b;
        end else if (w_s1_move) begin
            r_s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_s2_v    <= 1'b0;
            r_s2_diff <= '0;
            r_s2_sat  <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_v    <= 1'b1;
            r_s2_diff <= w_diff;
            r_s2_sat  <= w_sat;
        end else if (w_out_xfer) begin
            r_s2_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_txn_count <= '0;
        end else if (w_out_xfer) begin
            r_txn_count <= r_txn_count + 16'd1;
        end
    end

    assign out_valid = r_s2_v;
    assign out_diff  = r_s2_diff;
    assign out_sat   = r_s2_sat;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_sub_su_pipe.sv
// Directed bench for sub_su_pipe: a full-precision instance (OUT_W=10) and a saturating
// instance (OUT_W=8) share one stimulus stream; a queue scoreboard checks every result.
module tb_sub_su_pipe;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              in_valid;
    logic              out_ready;
    logic signed [7:0] a;
    logic [7:0]        b;

    logic              rdy10, rdy8, ov10, ov8, sat10, sat8;
    logic signed [9:0] diff10;
    logic signed [7:0] diff8;
    logic [15:0]       cnt10, cnt8;

    int errors = 0;
    int checks = 0;
    int q_full[$];
    bit rand_rdy = 1'b0;

    int bv_a[4], bv_b[4], bx10[4], bx8[4], bs8[4];

    always #5 clk = ~clk;

    sub_su_pipe #(.WIDTH(8), .OUT_W(10)) dut10 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy10),
        .a(a), .b(b), .out_valid(ov10), .out_ready(out_ready),
        .out_diff(diff10), .out_sat(sat10), .txn_count(cnt10)
    );

    sub_su_pipe #(.WIDTH(8), .OUT_W(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy8),
        .a(a), .b(b), .out_valid(ov8), .out_ready(out_ready),
        .out_diff(diff8), .out_sat(sat8), .txn_count(cnt8)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_to(input int v, input int ow);
        int mx = (1 << (ow - 1)) - 1;
        int mn = -(1 << (ow - 1));
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    // Scoreboard: record accepted pairs, compare each delivered result in order.
    always @(negedge clk) begin : sb
        int e;
        if (rst_b) begin
            if (in_valid && rdy10)
                q_full.push_back(int'(a) - int'(b));
            if (ov10 && out_ready) begin
                if (q_full.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    e = q_full.pop_front();
                    check("sb_v8", ov8, 1);
                    check("sb_d10", diff10, sat_to(e, 10));
                    check("sb_s10", sat10, 0);
                    check("sb_d8", diff8, sat_to(e, 8));
                    check("sb_s8", sat8, (e > 127 || e < -128) ? 1 : 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy)
            out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_in(input int av, input int bv);
        a = 8'(av);
        b = 8'(bv);
    endtask

    task automatic send(input int av, input int bv);
        int n = 0;
        in_valid = 1'b1;
        set_in(av, bv);
        @(negedge clk);
        while (!rdy10 && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((ov10 || q_full.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n++;
        end
        if (n >= 500)
            check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Back-to-back burst with out_ready high: result i appears exactly in cycle i+2.
    task automatic burst(input int n);
        for (int c = 0; c < n + 3; c++) begin
            if (c < n) begin
                in_valid = 1'b1;
                set_in(bv_a[c], bv_b[c]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("burst_rdy10", rdy10, 1);
            check("burst_rdy8", rdy8, 1);
            if (c >= 2 && c < n + 2) begin
                check("burst_v", ov10, 1);
                check("burst_d10", diff10, bx10[c-2]);
                check("burst_s10", sat10, 0);
                check("burst_d8", diff8, bx8[c-2]);
                check("burst_s8", sat8, bs8[c-2]);
            end else begin
                check("burst_idle_v", ov10, 0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_v", ov10, 0);
        check("rst_d10", diff10, 0);
        check("rst_s8", sat8, 0);
        check("rst_cnt", cnt10, 0);
        check("rst_rdy", rdy10, 1);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Full-precision burst.
        out_ready = 1'b1;
        bv_a = '{1, -47, -128, 127};
        bv_b = '{1, 29, 255, 0};
        bx10 = '{0, -76, -383, 127};
        bx8  = '{0, -76, -128, 127};
        bs8  = '{0, 0, 1, 0};
        burst(4);
        @(negedge clk);
        check("burst1_cnt10", cnt10, 4);
        check("burst1_cnt8", cnt8, 4);
        @(posedge clk);
        #1;

        // Saturation corners.
        bv_a = '{-128, -50, 127, -10};
        bv_b = '{255, 100, 0, 5};
        bx10 = '{-383, -150, 127, -15};
        bx8  = '{-128, -128, 127, -15};
        bs8  = '{1, 1, 0, 0};
        burst(4);
        @(negedge clk);
        check("burst2_cnt10", cnt10, 8);
        @(posedge clk);
        #1;

        // Backpressure: two entries accepted, third held, output stable.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(5, 3);
        @(negedge clk);
        check("bp_rdy_c0", rdy10, 1);
        check("bp_v_c0", ov10, 0);
        @(posedge clk);
        #1;
        set_in(-100, 200);
        @(negedge clk);
        check("bp_rdy_c1", rdy10, 1);
        check("bp_v_c1", ov10, 0);
        @(posedge clk);
        #1;
        set_in(100, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_rdy_stall", rdy10, 0);
            check("bp_rdy8_stall", rdy8, 0);
            check("bp_v_stall", ov10, 1);
            check("bp_hold_d10", diff10, 2);
            check("bp_hold_d8", diff8, 2);
            check("bp_hold_s8", sat8, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(100, 1);
        send(-1, 255);
        drain();
        @(negedge clk);
        check("bp_cnt", cnt10, 12);
        @(posedge clk);
        #1;

        // Random valid/ready toggling.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0)
                tick();
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("rand_cnt10", cnt10, 1012);
        check("rand_cnt8", cnt8, 1012);
        @(posedge clk);
        #1;

        // Asynchronous reset with both stages full and output stalled.
        out_ready = 1'b0;
        send(20, 10);
        send(30, 40);
        @(negedge clk);
        check("mid_full_v", ov10, 1);
        check("mid_full_rdy", rdy10, 0);
        #1;
        rst_b = 1'b0;
        #1;
        check("mid_rst_v", ov10, 0);
        check("mid_rst_d10", diff10, 0);
        check("mid_rst_d8", diff8, 0);
        check("mid_rst_s8", sat8, 0);
        check("mid_rst_cnt", cnt10, 0);
        check("mid_rst_rdy", rdy10, 1);
        q_full.delete();
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        bv_a[0] = -47;
        bv_b[0] = 29;
        bx10[0] = -76;
        bx8[0]  = -76;
        bs8[0]  = 0;
        burst(1);
        @(negedge clk);
        check("post_rst_cnt", cnt10, 1);
        @(posedge clk);
        #1;

        // Counter wrap: 65537 transfers since reset.
        for (int i = 0; i < 65534; i++)
            send((i % 256) - 128, (i * 7) % 256);
        drain();
        @(negedge clk);
        check("wrap_pre_cnt", cnt10, 65535);
        @(posedge clk);
        #1;
        send(3, 4);
        send(-3, 4);
        drain();
        @(negedge clk);
        check("wrap_cnt10", cnt10, 1);
        check("wrap_cnt8", cnt8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
